// File: rtl/bip_core.sv
// Accumulator CPU with internal program/data memories and single-step support.
// Optional retired-instruction counter: define BIP_RETIRED_COUNTER_EN. Requires DATA_LENGTH-5 >= ADDR_LENGTH.
module bip_core #(
  parameter int ADDR_LENGTH = 11,
  parameter int DATA_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   step_mode,
  input  logic                   step,
  input  logic                   pm_wr_en,
  input  logic [ADDR_LENGTH-1:0] pm_wr_addr,
  input  logic [DATA_LENGTH-1:0] pm_wr_data,
  output logic [ADDR_LENGTH-1:0] pc,
  output logic [DATA_LENGTH-1:0] acc,
  output logic                   busy,
  output logic                   halted,
  output logic [31:0]            retired
);

  localparam int OPER_W = DATA_LENGTH - 5;
  localparam int DEPTH  = 2 ** ADDR_LENGTH;

  localparam logic [4:0] OP_HLT  = 5'd0;
  localparam logic [4:0] OP_STO  = 5'd1;
  localparam logic [4:0] OP_LD   = 5'd2;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_SUBI = 5'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_PAUSE,
    S_HALT
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [DATA_LENGTH-1:0] r_pm [DEPTH];
  logic [DATA_LENGTH-1:0] r_dm [DEPTH];
  logic [DATA_LENGTH-1:0] r_instr;
  logic [ADDR_LENGTH-1:0] r_pc;
  logic [DATA_LENGTH-1:0] r_acc;

  logic [4:0]             w_opcode;
  logic [OPER_W-1:0]      w_operand;
  logic [ADDR_LENGTH-1:0] w_addr;
  logic [DATA_LENGTH-1:0] w_imm;
  logic [DATA_LENGTH-1:0] w_dm_rd;
  logic [DATA_LENGTH-1:0] w_acc_next;
  logic                   w_load_ok;
  logic                   w_start;
  logic                   w_exec;

  assign w_opcode  = r_instr[DATA_LENGTH-1 -: 5];
  assign w_operand = r_instr[OPER_W-1:0];
  assign w_addr    = w_operand[ADDR_LENGTH-1:0];
  assign w_imm     = {{5{w_operand[OPER_W-1]}}, w_operand};
  assign w_dm_rd   = r_dm[w_addr];

  // Program loading and (re)starting are only legal while the core is parked.
  assign w_load_ok = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_start   = w_load_ok && start;
  assign w_exec    = (r_state == S_EXEC);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_HALT: if (start) w_next = S_FETCH;
      S_FETCH:        w_next = S_EXEC;
      S_EXEC: begin
        if (w_opcode == OP_HLT) w_next = S_HALT;
        else if (step_mode)     w_next = S_PAUSE;
        else                    w_next = S_FETCH;
      end
      S_PAUSE:        if (step || !step_mode) w_next = S_FETCH;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_acc_next = r_acc;
    case (w_opcode)
      OP_LD:   w_acc_next = w_dm_rd;
      OP_LDI:  w_acc_next = w_imm;
      OP_ADD:  w_acc_next = r_acc + w_dm_rd;
      OP_ADDI: w_acc_next = r_acc + w_imm;
      OP_SUB:  w_acc_next = r_acc - w_dm_rd;
      OP_SUBI: w_acc_next = r_acc - w_imm;
      default: w_acc_next = r_acc;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_pc  <= '0;
      r_acc <= '0;
    end else if (w_exec) begin
      r_acc <= w_acc_next;
      if (w_opcode != OP_HLT) r_pc <= r_pc + ADDR_LENGTH'(1);
    end
  end

  // NOTE: memories and the instruction register carry no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (pm_wr_en && w_load_ok && !reset) r_pm[pm_wr_addr] <= pm_wr_data;
    if (r_state == S_FETCH) r_instr <= r_pm[r_pc];
  end

  always_ff @(posedge clk) begin
    if (w_exec && (w_opcode == OP_STO) && !reset) r_dm[w_addr] <= r_acc;
  end

`ifdef BIP_RETIRED_COUNTER_EN
  logic [31:0] r_retired;

  always_ff @(posedge clk) begin
    if (reset || w_start) r_retired <= '0;
    else if (w_exec)      r_retired <= r_retired + 32'd1;
  end

  assign retired = r_retired;
`else
  assign retired = '0;
`endif

  assign pc     = r_pc;
  assign acc    = r_acc;
  assign busy   = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_PAUSE);
  assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_bip_core.sv
// Directed testbench for bip_core: program execution, overflow, stepping, reset, load guard, pc wrap.
module tb_bip_core;

  localparam int AW = 11;
  localparam int DW = 16;
`ifdef BIP_RETIRED_COUNTER_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic          pm_wr_en = 1'b0;
  logic [AW-1:0] pm_wr_addr = '0;
  logic [DW-1:0] pm_wr_data = '0;
  logic [AW-1:0] pc;
  logic [DW-1:0] acc;
  logic          busy;
  logic          halted;
  logic [31:0]   retired;

  int passed = 0;
  int total  = 0;
  int n;

  bip_core #(.ADDR_LENGTH(AW), .DATA_LENGTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
    .pm_wr_en(pm_wr_en), .pm_wr_addr(pm_wr_addr), .pm_wr_data(pm_wr_data),
    .pc(pc), .acc(acc), .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ins(input logic [4:0] op, input logic [10:0] operand);
    return {op, operand};
  endfunction

  function automatic logic [31:0] exp_ret(input int cnt);
    return RET_EN ? 32'(cnt) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pm_wr_en = 1'b1; pm_wr_addr = a; pm_wr_data = d;
    tick();
    pm_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int cnt);
    cnt = 0;
    while (!halted && cnt < budget) begin
      tick();
      cnt++;
    end
  endtask

  task automatic load_basic();
    load(0, ins(3, 11'd5));   // LDI 5
    load(1, ins(5, 11'd3));   // ADDI 3
    load(2, ins(1, 11'd2));   // STO 2
    load(3, ins(7, 11'd1));   // SUBI 1
    load(4, ins(0, 11'd0));   // HLT
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; pm_wr_en = 1'b1; pm_wr_addr = '0; pm_wr_data = 16'hFFFF;
    tick(); tick();
    reset = 1'b0; start = 1'b0; pm_wr_en = 1'b0;
    total++; if (pc !== 0)      $display("FAIL reset_pc: got %0h want 0", pc); else passed++;
    total++; if (acc !== 0)     $display("FAIL reset_acc: got %0h want 0", acc); else passed++;
    total++; if (busy !== 0)    $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    total++; if (halted !== 0)  $display("FAIL reset_halted: got %0b want 0", halted); else passed++;
    total++; if (retired !== 0) $display("FAIL reset_retired: got %0d want 0", retired); else passed++;
  endtask

  task automatic test_basic();
    load_basic();
    pulse_start();
    total++; if (busy !== 1) $display("FAIL basic_busy: got %0b want 1", busy); else passed++;
    wait_halt(50, n);
    total++; if (n !== 10)     $display("FAIL basic_cycles: got %0d want 10", n); else passed++;
    total++; if (halted !== 1) $display("FAIL basic_halted: got %0b want 1", halted); else passed++;
    total++; if (acc !== 16'd7) $display("FAIL basic_acc: got %0h want 7", acc); else passed++;
    total++; if (pc !== 11'd4)  $display("FAIL basic_pc: got %0h want 4", pc); else passed++;
    total++; if (busy !== 0)    $display("FAIL basic_busy_end: got %0b want 0", busy); else passed++;
    total++; if (retired !== exp_ret(5)) $display("FAIL basic_retired: got %0d want %0d", retired, exp_ret(5)); else passed++;
    // read back dm[2] through LD
    load(0, ins(2, 11'd2));
    load(1, ins(0, 11'd0));
    pulse_start();
    wait_halt(50, n);
    total++; if (n !== 4)        $display("FAIL dm_read_cycles: got %0d want 4", n); else passed++;
    total++; if (acc !== 16'd8)  $display("FAIL dm2_value: got %0h want 8", acc); else passed++;
  endtask

  task automatic test_overflow();
    load(0, ins(3, 11'h7FF));  // LDI -1
    load(1, ins(5, 11'd1));    // ADDI 1
    load(2, ins(0, 11'd0));    // HLT
    pulse_start();
    tick(); tick();
    total++; if (acc !== 16'hFFFF) $display("FAIL ovf_ldi: got %0h want ffff", acc); else passed++;
    tick(); tick();
    total++; if (acc !== 16'h0000) $display("FAIL ovf_wrap: got %0h want 0", acc); else passed++;
    wait_halt(50, n);
    total++; if (halted !== 1)  $display("FAIL ovf_halted: got %0b want 1", halted); else passed++;
    total++; if (pc !== 11'd2)  $display("FAIL ovf_pc: got %0h want 2", pc); else passed++;
  endtask

  task automatic test_step();
    load_basic();
    step_mode = 1'b1;
    pulse_start();
    tick(); tick();
    total++; if (pc !== 11'd1)  $display("FAIL step_pc0: got %0h want 1", pc); else passed++;
    total++; if (acc !== 16'd5) $display("FAIL step_acc0: got %0h want 5", acc); else passed++;
    for (int i = 1; i <= 3; i++) begin
      repeat (3) tick();
      total++; if (pc !== 11'(i) || busy !== 1)
        $display("FAIL step_frozen%0d: got pc=%0h busy=%0b want pc=%0h busy=1", i, pc, busy, i);
      else passed++;
      step = 1'b1; tick(); step = 1'b0;
      tick(); tick();
    end
    total++; if (pc !== 11'd4 || acc !== 16'd7)
      $display("FAIL step_pause4: got pc=%0h acc=%0h want pc=4 acc=7", pc, acc);
    else passed++;
    // dropping step_mode while paused resumes execution
    step_mode = 1'b0;
    tick(); tick(); tick();
    total++; if (halted !== 1) $display("FAIL step_halted: got %0b want 1", halted); else passed++;
    total++; if (pc !== 11'd4 || acc !== 16'd7)
      $display("FAIL step_final: got pc=%0h acc=%0h want pc=4 acc=7", pc, acc);
    else passed++;
    total++; if (retired !== exp_ret(5)) $display("FAIL step_retired: got %0d want %0d", retired, exp_ret(5)); else passed++;
  endtask

  task automatic test_reset_mid();
    load(0, ins(2, 11'd2));   // LD 2
    load(1, ins(5, 11'd1));   // ADDI 1
    load(2, ins(1, 11'd2));   // STO 2
    load(3, ins(0, 11'd0));   // HLT
    pulse_start();
    repeat (5) tick();
    total++; if (acc !== 16'd9) $display("FAIL mid_pre_acc: got %0h want 9", acc); else passed++;
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (pc !== 0 || acc !== 0 || busy !== 0 || halted !== 0)
      $display("FAIL mid_reset: got pc=%0h acc=%0h busy=%0b halted=%0b want all 0", pc, acc, busy, halted);
    else passed++;
    pulse_start();
    wait_halt(50, n);
    total++; if (acc !== 16'd9) $display("FAIL mid_dm_kept: got %0h want 9", acc); else passed++;
    total++; if (pc !== 11'd3 || halted !== 1)
      $display("FAIL mid_rerun: got pc=%0h halted=%0b want pc=3 halted=1", pc, halted);
    else passed++;
  endtask

  task automatic test_write_guard();
    load(0, ins(3, 11'h011));
    load(1, ins(0, 11'd0));
    pulse_start();
    pm_wr_en = 1'b1; pm_wr_addr = '0; pm_wr_data = ins(3, 11'h022);
    tick();
    pm_wr_en = 1'b0;
    wait_halt(50, n);
    total++; if (acc !== 16'h11) $display("FAIL guard_run1: got %0h want 11", acc); else passed++;
    pulse_start();
    wait_halt(50, n);
    total++; if (acc !== 16'h11) $display("FAIL guard_ignored: got %0h want 11", acc); else passed++;
    pm_wr_en = 1'b1; pm_wr_addr = '0; pm_wr_data = ins(3, 11'h033); start = 1'b1;
    tick();
    pm_wr_en = 1'b0; start = 1'b0;
    wait_halt(50, n);
    total++; if (acc !== 16'h33) $display("FAIL guard_wr_start: got %0h want 33", acc); else passed++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 2 ** AW; i++)
      load(AW'(i), ins(5'(8 + (i % 24)), 11'(i)));
    pulse_start();
    repeat (2 * (2 ** AW - 1)) tick();
    total++; if (pc !== 11'h7FF || busy !== 1)
      $display("FAIL wrap_top: got pc=%0h busy=%0b want pc=7ff busy=1", pc, busy);
    else passed++;
    tick(); tick();
    total++; if (pc !== 11'h000 || busy !== 1 || halted !== 0)
      $display("FAIL wrap_zero: got pc=%0h busy=%0b halted=%0b want pc=0 busy=1 halted=0", pc, busy, halted);
    else passed++;
    total++; if (acc !== 16'd0) $display("FAIL wrap_acc: got %0h want 0", acc); else passed++;
    total++; if (retired !== exp_ret(2 ** AW))
      $display("FAIL wrap_retired: got %0d want %0d", retired, exp_ret(2 ** AW));
    else passed++;
    tick(); tick();
    total++; if (pc !== 11'h001 || busy !== 1)
      $display("FAIL wrap_cont: got pc=%0h busy=%0b want pc=1 busy=1", pc, busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_step();
    test_reset_mid();
    test_write_guard();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed so far", passed, total);
    $fatal(1, "timeout");
  end

endmodule
